slot_demux_receiver: RTL and testbench



---
 rtl/link_pkg.sv | 17 +
 rtl/slot_counter.sv | 23 ++
 rtl/slot_demux_receiver.sv | 107 ++++++++++
 tb/tb_slot_demux_receiver.sv | 130 +++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the time-slot one-hot link (transmitter and receiver).
package link_pkg;

  localparam int unsigned SLOTS_DEFAULT = 8;
  localparam int unsigned SEL_W_DEFAULT = 3;

  typedef enum logic {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Line pattern for slot 'sel'. Returned wide so any slot count up to 32 can use it.
  function automatic logic [31:0] onehot(input int unsigned sel);
    return 32'd1 << sel;
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Slot index counter: sync reset to 0, load to 1 on frame start, natural wrap on increment.
module slot_counter #(
  parameter int unsigned SEL_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt
);

  // Load has priority over increment so a realign always restarts at slot 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SEL_W'(1);
    end else if (inc) begin
      cnt <= cnt + SEL_W'(1);
    end
  end

endmodule

// File: rtl/slot_demux_receiver.sv
// Receive end of the one-hot time-slot link: aligns to SYNC, rebuilds the parallel
// word one bit per clock and reports each finished frame as VALID or ERR.
module slot_demux_receiver
  import link_pkg::*;
#(
  parameter int unsigned SLOTS = SLOTS_DEFAULT,
  parameter int unsigned SEL_W = SEL_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SYNC,
  input  logic [SLOTS-1:0] SLOT_IN,
  output logic [SLOTS-1:0] D_OUT,
  output logic             VALID,
  output logic             ERR,
  output logic             LOCKED
);

  state_e           state_q;
  logic [SEL_W-1:0] cnt;
  logic [SLOTS-1:0] acc_q, acc_d;
  logic             flag_q, flag_d;
  logic [SLOTS-1:0] d_out_q;
  logic             valid_q, err_q, locked_q;

  logic             start;
  logic             frame_end;
  logic [SEL_W-1:0] slot_idx;
  logic [SLOTS-1:0] line_exp;
  logic             hit;
  logic             bad;

  slot_counter #(
    .SEL_W(SEL_W)
  ) u_slot_counter (
    .CLK  (CLK),
    .RST  (RST),
    .load (start),
    .inc  (state_q == StRun),
    .cnt  (cnt)
  );

  // Slot decode and next accumulator/flag; a frame start (lock or realign) drops history.
  always_comb begin
    start     = SYNC && ((state_q == StHunt) || (cnt != '0));
    slot_idx  = start ? '0 : cnt;
    line_exp  = SLOTS'(onehot(32'(slot_idx)));
    hit       = (SLOT_IN == line_exp);
    bad       = (SLOT_IN != '0) && !hit;
    acc_d     = start ? '0 : acc_q;
    acc_d[slot_idx] = hit;
    flag_d    = (start ? 1'b0 : flag_q) | bad;
    // A realign on the last slot wins, so start suppresses frame end.
    frame_end = (state_q == StRun) && !start && (cnt == SEL_W'(SLOTS - 1));
  end

  // Lock FSM with registered word, strobes and lock indication.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StHunt;
      acc_q    <= '0;
      flag_q   <= 1'b0;
      d_out_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StHunt: begin
          if (SYNC) begin
            state_q  <= StRun;
            locked_q <= 1'b1;
            acc_q    <= acc_d;
            flag_q   <= flag_d;
          end
        end
        StRun: begin
          if (frame_end) begin
            if (flag_d) begin
              err_q <= 1'b1;
            end else begin
              d_out_q <= acc_d;
              valid_q <= 1'b1;
            end
            acc_q  <= '0;
            flag_q <= 1'b0;
          end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
          end
        end
        default: begin
          state_q  <= StHunt;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign D_OUT  = d_out_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_slot_demux_receiver.sv
// Directed bench for slot_demux_receiver: hand-computed frames, realigns, resets, errors.
module tb_slot_demux_receiver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SYNC;
  logic [7:0] SLOT_IN;
  logic [7:0] D_OUT;
  logic       VALID;
  logic       ERR;
  logic       LOCKED;

  int n_cmp = 0;
  int n_bad = 0;

  slot_demux_receiver dut (
    .CLK     (CLK),
    .RST     (RST),
    .SYNC    (SYNC),
    .SLOT_IN (SLOT_IN),
    .D_OUT   (D_OUT),
    .VALID   (VALID),
    .ERR     (ERR),
    .LOCKED  (LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_slot(input logic sync, input logic [7:0] lines);
    SYNC    = sync;
    SLOT_IN = lines;
    tick();
  endtask

  // Sends slots 0..upto-1 of a transmitter frame; slot bad_slot is replaced by bad_val.
  task automatic send_frame(input logic [7:0] data, input logic sync0, input int bad_slot,
                            input logic [7:0] bad_val, input int upto);
    logic [7:0] lines;
    for (int s = 0; s < upto; s++) begin
      lines = data[s] ? 8'(1 << s) : 8'h00;
      if (s == bad_slot) lines = bad_val;
      drive_slot(sync0 && (s == 0), lines);
      if (s < 7) begin
        chk("valid_mid", 32'(VALID), 32'd0);
        chk("err_mid", 32'(ERR), 32'd0);
        chk("locked_run", 32'(LOCKED), 32'd1);
      end
    end
  endtask

  task automatic chk_end(input string tag, input logic v, input logic e, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(VALID), 32'(v));
    chk({tag, "_err"}, 32'(ERR), 32'(e));
    chk({tag, "_dout"}, 32'(D_OUT), 32'(d));
  endtask

  initial begin
    // 1: reset then idle with all lines high and no SYNC.
    RST = 1'b1; SYNC = 1'b0; SLOT_IN = 8'h00;
    tick(); tick();
    chk_end("reset", 1'b0, 1'b0, 8'h00);
    chk("reset_locked", 32'(LOCKED), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_slot(1'b0, 8'hFF);
      chk_end("hunt_idle", 1'b0, 1'b0, 8'h00);
      chk("hunt_locked", 32'(LOCKED), 32'd0);
    end

    // 2: lock on SYNC, then back-to-back frames.
    send_frame(8'hAA, 1'b1, -1, 8'h00, 8);
    chk_end("frame_aa", 1'b1, 1'b0, 8'hAA);
    send_frame(8'hB4, 1'b0, -1, 8'h00, 8);
    chk_end("frame_b4", 1'b1, 1'b0, 8'hB4);

    // 3: wrong line in slot 2, then a clean frame.
    send_frame(8'h0F, 1'b0, 2, 8'h08, 8);
    chk_end("wrong_line", 1'b0, 1'b1, 8'hB4);
    send_frame(8'h55, 1'b0, -1, 8'h00, 8);
    chk_end("frame_55", 1'b1, 1'b0, 8'h55);

    // 4: realign at slot 4 of a frame that already carries an error.
    send_frame(8'hFF, 1'b0, 2, 8'h10, 4);
    send_frame(8'h3C, 1'b1, -1, 8'h00, 8);
    chk_end("realign4", 1'b1, 1'b0, 8'h3C);

    // SYNC together with slot 7: frame dropped, new frame starts there.
    send_frame(8'h99, 1'b0, -1, 8'h00, 7);
    send_frame(8'h66, 1'b1, -1, 8'h00, 8);
    chk_end("realign7", 1'b1, 1'b0, 8'h66);

    // 5: reset in slot 6, then activity without SYNC is ignored.
    send_frame(8'h5A, 1'b0, -1, 8'h00, 6);
    RST = 1'b1;
    drive_slot(1'b0, 8'h40);
    chk_end("rst_mid", 1'b0, 1'b0, 8'h00);
    chk("rst_mid_locked", 32'(LOCKED), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_slot(1'b0, 8'(1 << (i % 8)));
      chk_end("post_rst", 1'b0, 1'b0, 8'h00);
      chk("post_rst_locked", 32'(LOCKED), 32'd0);
    end

    // 6: two lines set in slot 0 of a 0x01 frame after a clean 0xC3.
    send_frame(8'hC3, 1'b1, -1, 8'h00, 8);
    chk_end("frame_c3", 1'b1, 1'b0, 8'hC3);
    send_frame(8'h01, 1'b0, 0, 8'h81, 8);
    chk_end("two_lines", 1'b0, 1'b1, 8'hC3);
    drive_slot(1'b0, 8'h00);
    chk_end("after_err", 1'b0, 1'b0, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
